griffin_nonlinear_tail: RTL
===========================

# griffin_nonlinear_tail

Completes the Griffin-3 nonlinear layer over the BN254 scalar field, directly downstream of `galois_pow_dinv`. It takes y0 = x0^(1/d) from that stage plus the untouched lanes x1 and x2, and computes the remaining lanes:
- y1 = x1^5
- y2 = x2·(L² + α·L + β), where L = y0 + y1 mod p

It uses one shared Barrett modular multiplier under a sequential FSM. Results feed the linear layer.

## Interface
Parameters:
- N_BITS, 254, field element width
- PRIME_MODULUS, 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, field prime p
- BARRETT_R, 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925, Barrett constant for p
- ALPHA, griffin_pkg::GRIFFIN_ALPHA2, lane-2 α, must be < p
- BETA, griffin_pkg::GRIFFIN_BETA2, lane-2 β, must be < p

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  start request, sampled only in IDLE
- y0_in  in  N_BITS  y0 from galois_pow_dinv, < p
- x1  in  N_BITS  lane-1 input, < p
- x2  in  N_BITS  lane-2 input, < p
- y0  out  N_BITS  captured y0_in, registered
- y1  out  N_BITS  x1^5 mod p, registered
- y2  out  N_BITS  lane-2 result, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States and order: IDLE → SQ1 → SQ2 → MUL3 → ADDL → SQL → MULA → ADDT → MULX → DONE → IDLE.
- IDLE, enable=1: capture y0_in, x1, x2 into operand registers; load y0 output; go to SQ1.
- Each state performs one operation, written at the end edge of that state:
  - SQ1: s ← x1·x1
  - SQ2: s ← s·s
  - MUL3: y1 ← s·x1
  - ADDL: L ← y0 + y1 mod p
  - SQL: q ← L·L
  - MULA: a ← ALPHA·L
  - ADDT: t ← (q + a mod p) + BETA mod p, two chained conditional subtractions in one cycle
  - MULX: y2 ← x2·t
  - DONE: done=1; go to IDLE
- Modular add: operands < p, sum computed at N_BITS+1 bits, subtract p if sum ≥ p; result always < p.
- Multiplier: full 2·N_BITS product with Barrett reduction and final correction, so the result is always < p. Purely combinational; registers live in this block.
- enable while busy: ignored, with no effect on operands or outputs.
- Outputs y0/y1/y2 hold their values until overwritten by the next operation.
  - y0 changes at the capture edge.
  - y1 and y2 change mid-operation at their writing states.
  - Consumers sample only on done.
- Reset, at any time including mid-operation: state → IDLE; y0, y1, y2, all internal registers → 0; busy=0; done=0. No partial result survives.

## Timing
- Capture edge E0 (enable=1 in IDLE). busy rises after E0. Results are final after E8. done=1 during the cycle between E8 and E9. IDLE after E9.
- Latency from enable-sampling edge to done high: 8 cycles. Minimum issue interval: 10 cycles. With enable held high, one operation completes every 10 cycles.
- done and busy are registered, decoded from the state register.
- Critical path is the multiplier plus Barrett reduction, the same class as galois_pow_dinv.

## Structure
- Shared package `griffin_pkg` holds:
  - N_BITS, PRIME_MODULUS, BARRETT_R
  - GRIFFIN_ALPHA2, GRIFFIN_BETA2
  - typedef `felem_t` (logic [N_BITS-1:0])
  - the FSM state enum `nl_tail_state_t`
- One sub-module, `galois_mod_mul`: combinational a·b mod p via Barrett, parameterised by N_BITS/PRIME_MODULUS/BARRETT_R. Operand muxing by state stays in the parent.
- Modular add is a local function in the parent.

## Test plan
All scenarios override ALPHA=2, BETA=3 unless stated.
- Zero vector: y0_in=0, x1=0, x2=0 → y1=0, y2=0; done exactly 8 cycles after the enable edge, 1 cycle wide.
- Small values: y0_in=1, x1=2, x2=1 → y1=32, L=33, t=1158, y2=1158; y0=1.
- Wrap at L: y0_in=p-1, x1=1, x2=5 → y1=1, L=0, t=3, y2=15.
- Negative-one lane: y0_in=0, x1=p-1, x2=1 → y1=p-1; t=(1 + (p-2) + 3) mod p = 2; y2=2.
- Reset during SQL:
  - Outputs and internals go to 0 and state to IDLE, with no done pulse.
  - A following enable with the small-values vector yields y2=1158.
- Protocol: enable toggled during busy is ignored, leaving the result unchanged. With enable held high, done pulses every 10 cycles with correct results. With default package ALPHA/BETA, random vectors are checked against a software Griffin reference model.

Source files
------------

// File: rtl/griffin_pkg.sv
// Shared constants, element type and FSM encoding for the Griffin-3 datapath
// over the BN254 scalar field.
package griffin_pkg;

  localparam int N_BITS = 254;

  localparam logic [N_BITS-1:0] PRIME_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  // floor(2^(2*N_BITS) / p), one bit wider than p
  localparam logic [N_BITS:0] BARRETT_R =
    255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925;

  localparam logic [N_BITS-1:0] GRIFFIN_ALPHA2 =
    254'h0e8b3cb2a0f5dd1b6f2c0a5b7b1d5e3e49a8d5c1b2f3e4d5c6b7a8091a2b3c4d;
  localparam logic [N_BITS-1:0] GRIFFIN_BETA2 =
    254'h21a5c6e3f07b4d9c8a1e2f3b4c5d6e7f8091a2b3c4d5e6f708192a3b4c5d6e7f;

  typedef logic [N_BITS-1:0] felem_t;

  typedef enum logic [3:0] {
    NL_IDLE,
    NL_SQ1,
    NL_SQ2,
    NL_MUL3,
    NL_ADDL,
    NL_SQL,
    NL_MULA,
    NL_ADDT,
    NL_MULX,
    NL_DONE
  } nl_tail_state_t;

endpackage

// File: rtl/galois_mod_mul.sv
// Combinational a*b mod p using Barrett reduction. The quotient estimate is
// at most two below the true quotient, so two conditional subtractions suffice.
module galois_mod_mul #(
  parameter int                  N_BITS        = griffin_pkg::N_BITS,
  parameter logic [N_BITS-1:0]   PRIME_MODULUS = griffin_pkg::PRIME_MODULUS,
  parameter logic [N_BITS:0]     BARRETT_R     = griffin_pkg::BARRETT_R
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] y
);

  localparam int W = N_BITS;
  localparam logic [W+1:0] P_EXT = {2'b00, PRIME_MODULUS};

  logic [2*W-1:0] z;
  logic [W:0]     q1;
  logic [2*W+1:0] q2;
  logic [W:0]     q3;
  logic [W+1:0]   qp;
  logic [W+1:0]   r0;
  logic [W+1:0]   r1;
  logic [W+1:0]   r2;

  always_comb begin
    z  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    q1 = z[2*W-1:W-1];
    q2 = {{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, BARRETT_R};
    q3 = q2[2*W+1:W+1];
    // Remainder is below 3p < 2^(W+2), so arithmetic modulo 2^(W+2) is exact.
    qp = {1'b0, q3} * P_EXT;
    r0 = z[W+1:0] - qp;
    r1 = (r0 >= P_EXT) ? r0 - P_EXT : r0;
    r2 = (r1 >= P_EXT) ? r1 - P_EXT : r1;
    y  = r2[W-1:0];
  end

endmodule

// File: rtl/griffin_nonlinear_tail.sv
// Griffin-3 nonlinear tail: y1 = x1^5, y2 = x2*(L^2 + alpha*L + beta) with
// L = y0 + y1, sequenced over one shared Barrett multiplier.
module griffin_nonlinear_tail #(
  parameter int                N_BITS        = griffin_pkg::N_BITS,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS,
  parameter logic [N_BITS:0]   BARRETT_R     = griffin_pkg::BARRETT_R,
  parameter logic [N_BITS-1:0] ALPHA         = griffin_pkg::GRIFFIN_ALPHA2,
  parameter logic [N_BITS-1:0] BETA          = griffin_pkg::GRIFFIN_BETA2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_BITS-1:0] y0_in,
  input  logic [N_BITS-1:0] x1,
  input  logic [N_BITS-1:0] x2,
  output logic [N_BITS-1:0] y0,
  output logic [N_BITS-1:0] y1,
  output logic [N_BITS-1:0] y2,
  output logic              busy,
  output logic              done
);

  import griffin_pkg::*;

  nl_tail_state_t state, state_next;

  logic [N_BITS-1:0] x1_q, x2_q, s_q, l_q, q_q, a_q, t_q;
  logic [N_BITS-1:0] y0_q, y1_q, y2_q;
  logic [N_BITS-1:0] mul_a, mul_b, mul_y;

  function automatic logic [N_BITS-1:0] mod_add(input logic [N_BITS-1:0] a,
                                                input logic [N_BITS-1:0] b);
    logic [N_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, PRIME_MODULUS}) sum = sum - {1'b0, PRIME_MODULUS};
    return sum[N_BITS-1:0];
  endfunction

  galois_mod_mul #(
    .N_BITS       (N_BITS),
    .PRIME_MODULUS(PRIME_MODULUS),
    .BARRETT_R    (BARRETT_R)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .y(mul_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= NL_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    mul_a      = '0;
    mul_b      = '0;
    unique case (state)
      NL_IDLE: if (enable) state_next = NL_SQ1;
      NL_SQ1:  begin mul_a = x1_q;  mul_b = x1_q; state_next = NL_SQ2;  end
      NL_SQ2:  begin mul_a = s_q;   mul_b = s_q;  state_next = NL_MUL3; end
      NL_MUL3: begin mul_a = s_q;   mul_b = x1_q; state_next = NL_ADDL; end
      NL_ADDL: state_next = NL_SQL;
      NL_SQL:  begin mul_a = l_q;   mul_b = l_q;  state_next = NL_MULA; end
      NL_MULA: begin mul_a = ALPHA; mul_b = l_q;  state_next = NL_ADDT; end
      NL_ADDT: state_next = NL_MULX;
      NL_MULX: begin mul_a = x2_q;  mul_b = t_q;  state_next = NL_DONE; end
      NL_DONE: state_next = NL_IDLE;
      default: state_next = NL_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register in this
  // block sees the pre-edge values of the others, regardless of statement order.
  // Every register is cleared on reset so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1_q <= '0; x2_q <= '0; s_q <= '0; l_q <= '0;
      q_q  <= '0; a_q  <= '0; t_q <= '0;
      y0_q <= '0; y1_q <= '0; y2_q <= '0;
    end else begin
      unique case (state)
        NL_IDLE: if (enable) begin
          y0_q <= y0_in;
          x1_q <= x1;
          x2_q <= x2;
        end
        NL_SQ1, NL_SQ2: s_q <= mul_y;
        NL_MUL3: y1_q <= mul_y;
        NL_ADDL: l_q  <= mod_add(y0_q, y1_q);
        NL_SQL:  q_q  <= mul_y;
        NL_MULA: a_q  <= mul_y;
        NL_ADDT: t_q  <= mod_add(mod_add(q_q, a_q), BETA);
        NL_MULX: y2_q <= mul_y;
        default: ;
      endcase
    end
  end

  assign y0   = y0_q;
  assign y1   = y1_q;
  assign y2   = y2_q;
  assign busy = (state != NL_IDLE);
  assign done = (state == NL_DONE);

endmodule
